// File: rtl/shift_seq_ctrl.sv
// Sequencer for a 4-mode universal shift register: load a job, then shift it out bit by bit.
// Optional rotate mode is enabled by defining SHIFT_SEQ_ROT_EN (adds port rot).
module shift_seq_ctrl #(
  parameter int N  = 4,
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_valid,
  output logic          start_ready,
  input  logic [N-1:0]  din,
  input  logic          dir,
  input  logic [CW-1:0] len,
  input  logic          fill,
`ifdef SHIFT_SEQ_ROT_EN
  input  logic          rot,
`endif
  input  logic          abort,
  input  logic [N-1:0]  q,
  output logic          s1,
  output logic          s0,
  output logic [N-1:0]  ld_data,
  output logic          lsi,
  output logic          rsi,
  output logic          ser_out,
  output logic          ser_valid,
  output logic          busy,
  output logic          done,
  output logic [1:0]    dbg_state
);

  // Handshake: a job is accepted on a rising edge where start_valid && start_ready;
  // start_ready is high only in IDLE, so all job inputs are ignored while busy.

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SHIFT = 2'd2, DONE = 2'd3} state_t;

  state_t        state;
  logic [N-1:0]  din_r;
  logic          dir_r;
  logic          fill_r;
  logic [CW-1:0] cnt;
  logic [CW-1:0] len_sat;
  logic          fill_out;

  assign len_sat = (len > CW'(N)) ? CW'(N) : len;

`ifdef SHIFT_SEQ_ROT_EN
  logic rot_r;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      din_r  <= '0;
      dir_r  <= 1'b0;
      fill_r <= 1'b0;
      cnt    <= '0;
`ifdef SHIFT_SEQ_ROT_EN
      rot_r  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            din_r  <= din;
            dir_r  <= dir;
            fill_r <= fill;
            cnt    <= len_sat;
`ifdef SHIFT_SEQ_ROT_EN
            rot_r  <= rot;
`endif
            state  <= LOAD;
          end
        end
        LOAD: begin
          if (abort)            state <= IDLE;
          else if (cnt != '0)   state <= SHIFT;
          else                  state <= DONE;
        end
        SHIFT: begin
          if (abort) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Moore decode from the state register only.
  assign start_ready = (state == IDLE);
  assign busy        = (state == LOAD) || (state == SHIFT);
  assign done        = (state == DONE);
  assign ser_valid   = (state == SHIFT);
  assign s1          = (state == LOAD) || ((state == SHIFT) && dir_r);
  assign s0          = (state == LOAD) || ((state == SHIFT) && !dir_r);
  assign ld_data     = din_r;
  assign dbg_state   = state;

  assign ser_out = (state == SHIFT) ? (dir_r ? q[0] : q[N-1]) : 1'b0;

`ifdef SHIFT_SEQ_ROT_EN
  // Rotating feeds the departing bit back in at the opposite end.
  assign fill_out = (rot_r && (state == SHIFT)) ? ser_out : fill_r;
`else
  assign fill_out = fill_r;
`endif

  assign lsi = (state == IDLE) ? 1'b0 : fill_out;
  assign rsi = (state == IDLE) ? 1'b0 : fill_out;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl with a behavioural universal shift register attached.
module tb_shift_seq_ctrl;
  localparam int N  = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start_valid = 1'b0;
  logic          start_ready;
  logic [N-1:0]  din = '0;
  logic          dir = 1'b0;
  logic [CW-1:0] len = '0;
  logic          fill = 1'b0;
  logic          rot = 1'b0;
  logic          abort = 1'b0;
  logic [N-1:0]  q = '0;
  logic          s1, s0, lsi, rsi, ser_out, ser_valid, busy, done;
  logic [N-1:0]  ld_data;
  logic [1:0]    dbg_state;

  int errs   = 0;
  int checks = 0;
  logic [0:0] exp_q[$];

  typedef struct {
    logic [N-1:0]  din;
    logic          dir;
    logic [CW-1:0] len;
    logic          fill;
    logic [N-1:0]  ser;
    int            nsh;
    logic [N-1:0]  qf;
  } vec_t;

  vec_t tbl[7];

  always #5 clk = ~clk;

  shift_seq_ctrl #(.N(N), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
    .din(din), .dir(dir), .len(len), .fill(fill),
`ifdef SHIFT_SEQ_ROT_EN
    .rot(rot),
`endif
    .abort(abort), .q(q), .s1(s1), .s0(s0), .ld_data(ld_data), .lsi(lsi), .rsi(rsi),
    .ser_out(ser_out), .ser_valid(ser_valid), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  always @(posedge clk) begin
    case ({s1, s0})
      2'b01:   q <= {q[N-2:0], lsi};
      2'b10:   q <= {rsi, q[N-1:1]};
      2'b11:   q <= ld_data;
      default: q <= q;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (rst && ser_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL ser_unexpected: got ser_valid=1 expected no serial bit at %0t", $time);
      end else begin
        logic [0:0] e;
        e = exp_q.pop_front();
        chk("ser_out", ser_out, e);
      end
    end
  end

  task automatic wait_ready();
    for (int i = 0; i < 20 && !start_ready; i++) begin
      @(posedge clk);
      #1;
    end
    chk("start_ready", start_ready, 1);
  endtask

  task automatic run_job(input vec_t v, input logic r);
    int k;
    wait_ready();
    for (int i = 0; i < v.nsh; i++) exp_q.push_back(v.ser[N-1-i]);
    din = v.din; dir = v.dir; len = v.len; fill = v.fill; rot = r;
    start_valid = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    din = $urandom_range(0, 15); dir = $urandom_range(0, 1); fill = $urandom_range(0, 1);
    chk("load_sel", {s1, s0}, 2'b11);
    chk("load_data", ld_data, v.din);
    chk("load_busy", busy, 1);
    for (k = 1; k <= v.nsh + 3; k++) begin
      @(posedge clk);
      #1;
      if (done) break;
      chk("shift_sel", {s1, s0}, v.dir ? 2'b10 : 2'b01);
    end
    chk("done_latency", k, v.nsh + 1);
    chk("q_final", q, v.qf);
    chk("sb_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
    chk("done_one_cycle", done, 0);
    chk("ready_after_done", start_ready, 1);
  endtask

  initial begin
    tbl[0] = '{4'b1011, 1'b0, 3'd4, 1'b0, 4'b1011, 4, 4'b0000};
    tbl[1] = '{4'b0110, 1'b1, 3'd2, 1'b1, 4'b0100, 2, 4'b1101};
    tbl[2] = '{4'b1001, 1'b0, 3'd0, 1'b0, 4'b0000, 0, 4'b1001};
    tbl[3] = '{4'b1100, 1'b0, 3'd7, 1'b1, 4'b1100, 4, 4'b1111};
    tbl[4] = '{4'b0101, 1'b1, 3'd1, 1'b0, 4'b1000, 1, 4'b0010};
    tbl[5] = '{4'b1010, 1'b0, 3'd3, 1'b1, 4'b1010, 3, 4'b0111};
    tbl[6] = '{4'b0011, 1'b1, 3'd5, 1'b0, 4'b1100, 4, 4'b0000};

    // reset state
    #1;
    chk("rst_sel", {s1, s0}, 2'b00);
    chk("rst_ld_data", ld_data, 0);
    chk("rst_lsi_rsi", {lsi, rsi}, 2'b00);
    chk("rst_ser", {ser_out, ser_valid}, 2'b00);
    chk("rst_busy_done", {busy, done}, 2'b00);
    chk("rst_ready", start_ready, 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 7; i++) run_job(tbl[i], 1'b0);

`ifdef SHIFT_SEQ_ROT_EN
    run_job('{4'b1000, 1'b0, 3'd4, 1'b0, 4'b1000, 4, 4'b1000}, 1'b1);
    run_job('{4'b0011, 1'b1, 3'd2, 1'b0, 4'b1100, 2, 4'b1100}, 1'b1);
`endif

    // abort after two shifts with the request held high throughout
    wait_ready();
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
    din = 4'b1011; dir = 1'b0; len = 3'd4; fill = 1'b0; rot = 1'b0;
    start_valid = 1'b1;
    @(posedge clk); #1;
    chk("abort_load_sel", {s1, s0}, 2'b11);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort_shift_sel", {s1, s0}, 2'b01);
    abort = 1'b1;
    @(posedge clk); #1;
    chk("abort_sel", {s1, s0}, 2'b00);
    chk("abort_no_done", done, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ready", start_ready, 1);
    chk("abort_q", q, 4'b1100);
    chk("abort_sb_empty", exp_q.size(), 0);
    exp_q.push_back(1'b1); exp_q.push_back(1'b0);
    exp_q.push_back(1'b1); exp_q.push_back(1'b1);
    @(posedge clk); #1;
    chk("held_accept_sel", {s1, s0}, 2'b11);
    chk("held_accept_busy", busy, 1);
    abort = 1'b0;
    start_valid = 1'b0;
    begin
      int k;
      for (k = 1; k <= 10; k++) begin
        @(posedge clk); #1;
        if (done) break;
      end
      chk("held_done_latency", k, 5);
    end
    chk("held_q", q, 4'b0000);
    chk("held_sb_empty", exp_q.size(), 0);

    // async reset in the middle of a shift
    wait_ready();
    exp_q.push_back(1'b1); exp_q.push_back(1'b0);
    din = 4'b1011; dir = 1'b0; len = 3'd4; fill = 1'b1;
    start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk("mid_rst_sel", {s1, s0}, 2'b00);
    chk("mid_rst_ld_data", ld_data, 0);
    chk("mid_rst_lsi_rsi", {lsi, rsi}, 2'b00);
    chk("mid_rst_ser", {ser_out, ser_valid}, 2'b00);
    chk("mid_rst_busy_done", {busy, done}, 2'b00);
    chk("mid_rst_ready", start_ready, 1);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", start_ready, 1);
    chk("post_rst_idle", {busy, done, ser_valid}, 3'b000);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
